// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with redirect, halt and 1-entry skid buffer
// Keeps a PC, issues word reads to a 1-cycle synchronous imem and presents one instruction at a time.
module instr_fetch_unit #(
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'd63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic              redirect_absolute,
    input  logic [31:0]       offset,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              halted
);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              valid_q, valid_d;
    logic [31:0]       skid_data_q, skid_data_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic              consume;
    logic              halt_take;
    logic              redir_take;
    logic              flush;
    logic [1:0]        occ;
    logic              room;
    logic              issue;
    logic [ADDR_W-1:0] target;
    logic              unused_offset_bits;

    assign unused_offset_bits = ^offset[31:ADDR_W];

    // Halt wins over a simultaneous redirect; both only act on a presented instruction.
    assign consume    = valid_q & (~stall | redirect);
    assign halt_take  = consume & (instr_q[31:26] == HALT_OPCODE);
    assign redir_take = valid_q & redirect & ~halt_take;
    assign flush      = halt_take | redir_take;

    // Words held or in flight after this cycle must fit in output + skid.
    assign occ   = {1'b0, valid_q} + {1'b0, skid_valid_q} + {1'b0, pending_q};
    assign room  = consume ? (occ <= 2'd2) : (occ <= 2'd1);
    assign issue = (state_q == S_RUN) & ~rst & ~flush & room;

    assign target = redirect_absolute ? offset[ADDR_W-1:0]
                                      : pc_out_q + ADDR_W'(1) + offset[ADDR_W-1:0];

    assign imem_rd_en  = issue;
    assign imem_addr   = fetch_pc_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == S_HALTED);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        pending_d    = 1'b0;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            S_RUN: begin
                if (issue) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    pending_d  = 1'b1;
                    pend_pc_d  = fetch_pc_q;
                end
                if (flush) begin
                    valid_d      = 1'b0;
                    skid_valid_d = 1'b0;
                    pending_d    = 1'b0;
                    if (halt_take) begin
                        state_d = S_HALTED;
                    end else begin
                        fetch_pc_d = target;
                    end
                end else if (consume) begin
                    if (skid_valid_q) begin
                        instr_d      = skid_data_q;
                        pc_out_d     = skid_pc_q;
                        skid_valid_d = pending_q;
                        if (pending_q) begin
                            skid_data_d = imem_rdata;
                            skid_pc_d   = pend_pc_q;
                        end
                    end else if (pending_q) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pend_pc_q;
                        valid_d  = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (pending_q) begin
                    // Output occupied and held: the single in-flight word parks in the skid.
                    if (valid_q) begin
                        skid_data_d  = imem_rdata;
                        skid_pc_d    = pend_pc_q;
                        skid_valid_d = 1'b1;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pend_pc_q;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                valid_d      = 1'b0;
                skid_valid_d = 1'b0;
            end
            default: begin
                state_d = S_HALTED;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_RUN;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            pending_q    <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            pending_q    <= pending_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              redirect;
    logic              redirect_absolute;
    logic [31:0]       offset;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] pc_out;
    logic              instr_valid;
    logic              halted;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int n_cmp;
    int n_err;

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (10'd0),
        .HALT_OPCODE(6'd63)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_absolute(redirect_absolute),
        .offset           (offset),
        .imem_rd_en       (imem_rd_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .instruction      (instruction),
        .pc_out           (pc_out),
        .instr_valid      (instr_valid),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_absolute = 1'b0;
        offset = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        imem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = i;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_absolute = 1'b0;
        offset = '0;

        // reset state
        #1;
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_rd_en", imem_rd_en, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_pc_out", pc_out, 0);
        check_eq("rst_instr", instruction, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // streaming from reset, cycles 0..6
        for (int c = 0; c < 7; c++) begin
            #1;
            check_eq("t1_rd_en", imem_rd_en, 1);
            check_eq("t1_addr", imem_addr, c);
            check_eq("t1_valid", instr_valid, (c >= 2));
            if (c >= 2) begin
                check_eq("t1_pc_out", pc_out, c - 2);
                check_eq("t1_instr", instruction, c - 2);
            end
            tick();
        end

        // stall three cycles on pc_out=5
        stall = 1'b1;
        for (int c = 7; c < 10; c++) begin
            #1;
            check_eq("t2_hold_pc", pc_out, 5);
            check_eq("t2_hold_instr", instruction, 5);
            check_eq("t2_hold_valid", instr_valid, 1);
            check_eq("t2_rd_en_off", imem_rd_en, 0);
            tick();
        end
        stall = 1'b0;
        #1;
        check_eq("t2_release_pc", pc_out, 5);
        check_eq("t2_release_rd_en", imem_rd_en, 1);
        check_eq("t2_release_addr", imem_addr, 7);
        tick();
        for (int c = 11; c < 14; c++) begin
            #1;
            check_eq("t2_resume_valid", instr_valid, 1);
            check_eq("t2_resume_pc", pc_out, c - 5);
            check_eq("t2_resume_instr", instruction, c - 5);
            tick();
        end

        // relative redirect at pc_out=4
        do_reset();
        repeat (6) tick();
        check_eq("t3_pc_before", pc_out, 4);
        redirect = 1'b1;
        redirect_absolute = 1'b0;
        offset = 32'hFFFF_FFFD;
        #1;
        check_eq("t3_no_issue", imem_rd_en, 0);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t3_bubble1", instr_valid, 0);
        check_eq("t3_tgt_rd_en", imem_rd_en, 1);
        check_eq("t3_tgt_addr", imem_addr, 2);
        tick();
        check_eq("t3_bubble2", instr_valid, 0);
        tick();
        check_eq("t3_valid", instr_valid, 1);
        check_eq("t3_pc", pc_out, 2);
        check_eq("t3_instr", instruction, 2);
        tick();
        check_eq("t3_next_pc", pc_out, 3);

        // absolute redirect to top of address space, then wrap
        redirect = 1'b1;
        redirect_absolute = 1'b1;
        offset = 32'h0000_03FF;
        #1;
        check_eq("t4_no_issue", imem_rd_en, 0);
        tick();
        offset = 32'h0000_0005;
        #1;
        check_eq("t4_ign_valid", instr_valid, 0);
        check_eq("t4_ign_rd_en", imem_rd_en, 1);
        check_eq("t4_ign_addr", imem_addr, 10'h3FF);
        tick();
        redirect = 1'b0;
        redirect_absolute = 1'b0;
        offset = '0;
        tick();
        check_eq("t4_top_valid", instr_valid, 1);
        check_eq("t4_top_pc", pc_out, 10'h3FF);
        check_eq("t4_top_instr", instruction, 32'h3FF);
        tick();
        check_eq("t4_wrap_pc", pc_out, 0);
        check_eq("t4_wrap_instr", instruction, 0);
        check_eq("t4_wrap_valid", instr_valid, 1);

        // halt word at pc 7, consumed together with a redirect
        mem[7] = {6'd63, 26'd0};
        do_reset();
        repeat (9) tick();
        check_eq("t5_pc", pc_out, 7);
        check_eq("t5_instr", instruction, 32'hFC00_0000);
        redirect = 1'b1;
        redirect_absolute = 1'b1;
        offset = '0;
        #1;
        check_eq("t5_no_issue", imem_rd_en, 0);
        tick();
        for (int c = 0; c < 22; c++) begin
            redirect = c[0];
            #1;
            check_eq("t5_halted", halted, 1);
            check_eq("t5_valid", instr_valid, 0);
            check_eq("t5_rd_en", imem_rd_en, 0);
            tick();
        end
        redirect = 1'b0;
        mem[7] = 32'd7;

        // reset pulsed while stalled with the skid full
        do_reset();
        check_eq("t6_halted_clr", halted, 0);
        repeat (7) tick();
        stall = 1'b1;
        check_eq("t6_pc_stall", pc_out, 5);
        tick();
        check_eq("t6_pc_held", pc_out, 5);
        rst = 1'b1;
        #1;
        check_eq("t6_async_valid", instr_valid, 0);
        check_eq("t6_async_pc", pc_out, 0);
        check_eq("t6_async_instr", instruction, 0);
        check_eq("t6_async_rd_en", imem_rd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        #1;
        check_eq("t6_restart_rd_en", imem_rd_en, 1);
        check_eq("t6_restart_addr", imem_addr, 0);
        check_eq("t6_restart_valid", instr_valid, 0);
        tick();
        check_eq("t6_c1_valid", instr_valid, 0);
        tick();
        check_eq("t6_c2_valid", instr_valid, 1);
        check_eq("t6_c2_pc", pc_out, 0);
        check_eq("t6_c2_instr", instruction, 0);
        tick();
        check_eq("t6_c3_pc", pc_out, 1);
        check_eq("t6_c3_instr", instruction, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues word reads to a synchronous instruction memory.
- Presents one instruction at a time (instruction, pc_out, instr_valid) to the control unit and datapath.
- Accepts taken-branch/jump redirects resolved downstream; a 1-entry skid buffer keeps throughput at one instruction per cycle across downstream stalls.

Parameters:
- ADDR_W, 10: width of the word-addressed PC and the imem address.
- RESET_PC, 0: first fetch address after reset.
- HALT_OPCODE, 63: value of instruction[31:26] that halts fetch when consumed.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  downstream cannot accept the presented instruction this cycle.
- redirect  input  1  presented instruction is a taken branch/jump; resolved this cycle.
- redirect_absolute  input  1  1: target = offset; 0: target is PC-relative.
- offset  input  32  branch/jump offset or absolute target from the control unit.
- imem_rd_en  output  1  read request this cycle.
- imem_addr  output  ADDR_W  read word address.
- imem_rdata  input  32  read data, valid the cycle after the request.
- instruction  output  32  presented instruction.
- pc_out  output  ADDR_W  word address of the presented instruction.
- instr_valid  output  1  instruction/pc_out are valid.
- halted  output  1  fetch stopped by HALT_OPCODE.

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc=RESET_PC; instruction=0, pc_out=0, instr_valid=0.
  - Skid empty, pending=0, halted=0, state=RUN.
  - imem_rd_en=0 during reset.
- State machine:
  - RUN: normal fetching.
  - HALTED: absorbing; left only by rst.
- Memory timing:
  - Request in cycle t (imem_rd_en=1, imem_addr=fetch_pc).
  - imem_rdata is valid in t+1.
  - The response is captured at the end of t+1 into the output register if it is free or being consumed, otherwise into the skid register.
  - pending=1 marks a request issued in the previous cycle.
- Consume: a cycle with instr_valid=1 and (stall=0 or redirect=1). On consume, skid (if valid) moves into the output register before new data.
- Issue rule (RUN only):
  - imem_rd_en=1 when (instr_valid + skid_valid + pending − consume) ≤ 1 and no redirect/halt consume this cycle.
  - On issue, fetch_pc <= fetch_pc+1, mod 2^ADDR_W.
  - Steady state with stall=0 gives one instruction per cycle, no bubbles.
  - Data is never lost or duplicated.
- Stall: while instr_valid=1 and stall=0 is not met, instruction and pc_out hold. At most one in-flight response lands in the skid buffer. Issue stops.
- Redirect (honoured only when instr_valid=1; ignored otherwise; takes priority over stall):
  - Target = offset[ADDR_W-1:0] if redirect_absolute, else pc_out + 1 + offset[ADDR_W-1:0], mod 2^ADDR_W.
  - fetch_pc <= target; skid cleared; pending cleared, so next cycle's imem_rdata is discarded; instr_valid <= 0.
  - No issue in the redirect cycle. Target is requested in t+1 and presented (instr_valid=1) in t+3.
- Halt: consuming an instruction with instruction[31:26]==HALT_OPCODE:
  - state <= HALTED, halted <= 1, instr_valid <= 0.
  - Skid and pending cleared; imem_rd_en=0 permanently.
  - Halt beats a simultaneous redirect.
- instr_valid=0 ⇒ instruction and pc_out hold their last values (don't-care for consumers).
- rst mid-operation: everything returns to reset values immediately. In-flight data arriving after reset release is discarded.

Test Plan:
1. Reset release, imem[i]=i, stall=0 → imem_addr 0,1,2… from cycle 0; instr_valid=1 from cycle 2; pc_out/instruction = 0,1,2… one per cycle, no gaps.
2. Stall held 3 cycles while pc_out=5 → instruction=5 held; imem_rd_en drops after at most one more request; on release pc_out = 6,7,8 back-to-back, no duplicate or missing word.
3. Relative redirect at pc_out=4, offset=0xFFFFFFFD → words 5 and 6 never presented; instr_valid=0 for 2 cycles; pc_out=2 valid 3 cycles after redirect.
4. ADDR_W=10:
   - Absolute redirect offset=0x3FF → pc_out=1023 next valid, followed by pc_out=0 (wrap).
   - Redirect while instr_valid=0 → ignored.
5. Word at pc 7 = {6'd63,26'd0}, consumed with redirect=1 → halted=1 next cycle; instr_valid=0; imem_rd_en=0 for 20+ cycles; redirect ignored.
6. rst pulsed while stalled with skid full → outputs cleared asynchronously; after release, fetch restarts at RESET_PC; stale data never presented.
